// File: rtl/apb_ctrl_pkg.sv
// apb_ctrl_pkg: shared FSM state type, default bus widths and packed-vector field extraction.
package apb_ctrl_pkg;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_t;
    localparam int DEF_AW = 8;
    localparam int DEF_DW = 32;
    localparam int FW = 64;
    localparam int PW = FW * 8;
    // Field i of width w from a packed vector (up to 8 fields of up to 64 bits).
    function automatic logic [FW-1:0] pick(input logic [PW-1:0] vec, input int i, input int w);
        return vec[i*w +: FW] & ~({FW{1'b1}} << w);
    endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first request after the last-served index.
module rr_arbiter #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0]         i_req,
    input  logic [$clog2(N_REQ)-1:0] i_last,
    input  logic                     i_en,
    output logic [N_REQ-1:0]         o_gnt,
    output logic [$clog2(N_REQ)-1:0] o_idx
);
    // Scan farthest-first so the nearest valid index after i_last is written last and wins.
    always_comb begin
        o_gnt = '0;
        o_idx = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            if (i_en && i_req[(int'(i_last) + k) % N_REQ]) begin
                o_gnt = N_REQ'(1) << ((int'(i_last) + k) % N_REQ);
                o_idx = $clog2(N_REQ)'((int'(i_last) + k) % N_REQ);
            end
        end
    end
endmodule

// File: rtl/apb_rr_master.sv
// apb_rr_master: round-robin APB master sharing one slave among N_REQ requesters.
// Define APB_TIMEOUT_EN to abort ACCESS with an error after TIMEOUT wait cycles.
module apb_rr_master import apb_ctrl_pkg::*; #(
    parameter int N_REQ   = 4,
    parameter int AW      = DEF_AW,
    parameter int DW      = DEF_DW,
    parameter int TIMEOUT = 16
) (
    input  logic                i_PCLK,
    input  logic                i_PRESET,
    input  logic [N_REQ-1:0]    i_req_valid,
    input  logic [N_REQ-1:0]    i_req_write,
    input  logic [N_REQ*AW-1:0] i_req_addr,
    input  logic [N_REQ*DW-1:0] i_req_wdata,
    output logic [N_REQ-1:0]    o_req_ack,
    output logic [DW-1:0]       o_rsp_rdata,
    output logic                o_rsp_err,
    output logic                o_PSEL1,
    output logic                o_PENABLE,
    output logic                o_PWRITE,
    output logic [AW-1:0]       o_PADDR,
    output logic [DW-1:0]       o_PWDATA,
    input  logic [DW-1:0]       i_PRDATA,
    input  logic                i_PREADY,
    input  logic                i_PSLVERR
);
    localparam int IW = $clog2(N_REQ);
    state_t r_state, w_next;
    logic [IW-1:0] r_last, r_idx, w_idx;
    logic [N_REQ-1:0] r_gnt, w_gnt, r_ack;
    logic r_write, r_psel, r_pen, r_err, w_to;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_wdata, r_rdata;

    rr_arbiter #(.N_REQ(N_REQ)) u_arb (
        .i_req  (i_req_valid),
        .i_last (r_last),
        .i_en   (r_state == IDLE),
        .o_gnt  (w_gnt),
        .o_idx  (w_idx)
    );

`ifdef APB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT + 1);
    logic [CW-1:0] r_cnt;
    always_ff @(posedge i_PCLK or posedge i_PRESET) begin
        if (i_PRESET) r_cnt <= '0;
        else r_cnt <= (r_state == ACCESS && !i_PREADY) ? r_cnt + CW'(1) : '0;
    end
    assign w_to = !i_PREADY && r_cnt == CW'(TIMEOUT - 1);
`else
    assign w_to = TIMEOUT < 0;
`endif

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:    w_next = |w_gnt ? SETUP : IDLE;
            SETUP:   w_next = ACCESS;
            ACCESS:  w_next = (i_PREADY || w_to) ? DONE : ACCESS;
            default: w_next = IDLE;
        endcase
    end

    // Outputs are computed from the next state so every APB/response pin comes straight off a flop.
    always_ff @(posedge i_PCLK or posedge i_PRESET) begin
        if (i_PRESET) begin
            r_state <= IDLE;
            r_last  <= IW'(N_REQ - 1);
            r_idx   <= '0;
            r_gnt   <= '0;
            r_write <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_psel  <= 1'b0;
            r_pen   <= 1'b0;
            r_ack   <= '0;
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else begin
            r_state <= w_next;
            if (r_state == IDLE && |w_gnt) begin
                r_idx   <= w_idx;
                r_gnt   <= w_gnt;
                r_write <= i_req_write[w_idx];
                r_addr  <= AW'(pick(PW'(i_req_addr), int'(w_idx), AW));
                r_wdata <= i_req_write[w_idx] ? DW'(pick(PW'(i_req_wdata), int'(w_idx), DW)) : '0;
            end
            if (r_state == DONE) r_last <= r_idx;
            r_psel  <= w_next == SETUP || w_next == ACCESS;
            r_pen   <= w_next == ACCESS;
            r_ack   <= w_next == DONE ? r_gnt : '0;
            r_rdata <= (w_next == DONE && i_PREADY && !r_write) ? i_PRDATA : '0;
            r_err   <= w_next == DONE && (!i_PREADY || i_PSLVERR);
        end
    end

    assign o_PSEL1     = r_psel;
    assign o_PENABLE   = r_pen;
    assign o_PWRITE    = r_write;
    assign o_PADDR     = r_addr;
    assign o_PWDATA    = r_wdata;
    assign o_req_ack   = r_ack;
    assign o_rsp_rdata = r_rdata;
    assign o_rsp_err   = r_err;
endmodule

// File: doc/apb_rr_master.md
Name: apb_rr_master

Overview:
- Round-robin APB master that shares one APB slave (the apb_mem slave port: PSEL1/PENABLE/PWRITE/PADDR/PWDATA/PRDATA/PREADY/PSLVERR) between N_REQ local requesters.
- Each requester posts one read or write; the block arbitrates, runs the APB SETUP/ACCESS sequence, honours PREADY wait states, and returns PRDATA/PSLVERR with a one-cycle ack.
- Sits between requester logic and the existing APB memory slave in tb_top-style integration.

Parameters:
- N_REQ, 4, number of requesters (2..8).
- AW, 8, APB address width.
- DW, 32, APB data width.
- TIMEOUT, 16, max ACCESS cycles awaiting PREADY (used only with APB_TIMEOUT_EN).

Ports:
- _PCLK  in  1  APB clock; all state updates on the rising edge.
- _PRESET  in  1  asynchronous, active-high reset.
- req_valid  in  N_REQ  per-requester request; held with stable payload until its ack.
- req_write  in  N_REQ  1=write, 0=read.
- req_addr  in  N_REQ*AW  packed addresses; requester i at [i*AW +: AW].
- req_wdata  in  N_REQ*DW  packed write data.
- req_ack  out  N_REQ  one-hot completion pulse, one cycle.
- rsp_rdata  out  DW  read data, valid while any req_ack is high; 0 for writes.
- rsp_err  out  1  PSLVERR (or timeout) of the completing transfer, valid with req_ack.
- _PSEL1, _PENABLE, _PWRITE  out  1 each  APB controls.
- _PADDR  out  AW;  _PWDATA  out  DW.
- _PRDATA  in  DW;  _PREADY, _PSLVERR  in  1 each.

Behaviour:
- Reset (asynchronous, immediate, including mid-transfer):
  - All outputs 0; state IDLE; round-robin pointer last=N_REQ-1, so requester 0 has first priority.
  - An in-flight transfer is abandoned and not acked.
- FSM: IDLE -> SETUP -> ACCESS -> DONE -> IDLE. All APB outputs are registered.
- IDLE:
  - If any req_valid is high, grant the first valid index searching last+1, last+2, … modulo N_REQ.
  - Latch grant index, write, addr and wdata; go to SETUP.
  - Otherwise stay in IDLE with _PSEL1=0.
- SETUP (1 cycle):
  - _PSEL1=1, _PENABLE=0, _PADDR/_PWRITE/_PWDATA from the latch (_PWDATA=0 on reads); go to ACCESS.
- ACCESS:
  - _PSEL1=1, _PENABLE=1, address/control held stable.
  - On an edge with _PREADY=1: capture _PRDATA (reads only) and _PSLVERR, then go to DONE.
  - With _PREADY=0: stay in ACCESS (unbounded without the optional feature).
- DONE (1 cycle):
  - _PSEL1=0, _PENABLE=0; req_ack[grant]=1; rsp_rdata/rsp_err drive the captured values.
  - last <= grant; go to IDLE.
  - rsp_rdata/rsp_err return to 0 in every cycle that is not DONE.
- Requester rule: sample req_ack at the DONE edge and drop or replace req_valid before the following IDLE edge.
- Minimum latency: grant edge to ack-high is 3 cycles (zero-wait slave); throughput is one transfer per 4 cycles plus wait states.
- Simultaneous requests: strict rotation, so no requester waits for more than N_REQ-1 other transfers.
- Requests that deassert while not granted are ignored. Payload changes during a transfer have no effect because the payload is latched at grant.
- Addresses are passed unchanged; no range check.

Optional Feature:
- APB_TIMEOUT_EN defined:
  - A cycle counter clears on ACCESS entry and increments each ACCESS cycle with _PREADY=0.
  - When the count reaches TIMEOUT, go to DONE with rsp_err=1 and rsp_rdata=0, and drop _PSEL1/_PENABLE.
  - _PREADY=1 on the same edge wins and completes normally.
- Undefined: no counter; ACCESS waits indefinitely; the TIMEOUT parameter is unused.

Decomposition:
- Package apb_ctrl_pkg: state enum (IDLE, SETUP, ACCESS, DONE), default AW/DW constants, and a function that extracts requester i's addr/wdata from the packed vectors.
- Sub-module rr_arbiter:
  - Parameterised by N_REQ.
  - Inputs: req vector, last pointer, enable.
  - Outputs: one-hot grant and grant index.
  - Purely combinational; pointer state stays in the parent.

Test Plan:
- Single write: req 0 writes addr 0x10, data 0xDEADBEEF, slave PREADY=1 -> _PSEL1 rises 1 cycle after grant, _PENABLE 1 cycle later, req_ack[0] 1 cycle after that, rsp_err=0; then req 2 reads 0x10 -> rsp_rdata=0xDEADBEEF.
- Wait states: slave holds PREADY=0 for 3 ACCESS cycles -> _PENABLE high for 4 cycles, _PADDR stable throughout, ack on the cycle after PREADY.
- Contention: req 0..3 all valid from reset -> ack order 0,1,2,3; then req 1 and 3 re-request -> order 1,3 after last=3.
- Error: slave drives PSLVERR=1 on a write to 0xFF -> req_ack with rsp_err=1 and rsp_rdata=0.
- Reset mid-ACCESS: assert _PRESET while PREADY=0 -> all outputs 0 immediately, no ack; after release, req 0 is served first.
- APB_TIMEOUT_EN with TIMEOUT=16 and PREADY held 0 -> ack after 16 ACCESS cycles with rsp_err=1; without the macro -> no ack.
